hl2link_rx: RTL
===============

Name: hl2link_rx

Overview:
- Receive end of the 2-lane inter-board serial link: deserializes frames arriving on `linkrx[1:0]` and delivers 32-bit words to core logic.
- Counterpart of the link transmitter that drives `linktx[1:0]`.
- Sits inside `hermeslite_core` when HL2LINK is enabled. Runs entirely in the core clock domain.
- Lanes are asynchronous to `clk` and oversampled.

Parameters:
- OVERSAMPLE, 4: clock cycles per dibit. Must be even and >= 4.
- SYNC_STAGES, 2: synchronizer flops per lane. Must be >= 2.

Ports:
- `clk`  input  1  core clock
- `rst`  input  1  synchronous reset, active high
- `linkrx`  input  2  serial lanes, asynchronous. Lane 1 carries the MSB of each dibit. Idle = 2'b11.
- `rx_data`  output  32  received word
- `rx_valid`  output  1  `rx_data` holds an unconsumed word
- `rx_ready`  input  1  consumer accepts the word when `rx_valid` & `rx_ready`
- `frame_err`  output  1  one-cycle pulse: bad stop dibit, or parity failure (macro builds only)
- `overrun`  output  1  one-cycle pulse: good frame dropped because the holding register was full
- `busy`  output  1  high from start detection until the frame ends

Behaviour:
- Reset values:
  - `rx_data` = 0; `rx_valid`, `frame_err`, `overrun`, `busy` = 0.
  - Synchronizer flops = 2'b11; FSM = IDLE; counters = 0.
  - Reset mid-frame discards the frame and does not pulse `frame_err`.
- Frame format, one dibit per OVERSAMPLE cycles:
  - start 2'b00;
  - 16 data dibits, MSB dibit first;
  - parity dibit: bit1 = XOR of the 16 lane-1 data bits, bit0 = XOR of the 16 lane-0 data bits;
  - stop 2'b11.
- FSM states:
  - IDLE: `busy` = 0. When synced lanes == 2'b00 → START; phase counter = 1.
  - START: count to OVERSAMPLE/2 (dibit midpoint) and re-sample. Lanes == 2'b00 → DATA with phase = 0. Otherwise treat as a glitch → IDLE, no error.
  - DATA: sample when phase == OVERSAMPLE-1. Shift in: `shreg` <= {`shreg`[29:0], lanes}. Accumulate lane parities. After 16 samples → PARITY.
  - PARITY: sample one dibit and store it → STOP.
  - STOP: sample one dibit.
    - Stop != 2'b11 → pulse `frame_err`, then → WAITIDLE.
    - Stop == 2'b11 and no error → deliver the word, then → IDLE.
  - WAITIDLE: remain until synced lanes == 2'b11 for one cycle → IDLE. `busy` stays 1.
- Phase counter: width clog2(OVERSAMPLE). Wraps to 0 after OVERSAMPLE-1.
- Delivery rules:
  - `rx_valid` and `rx_data` update the cycle after the stop sample.
  - If the holding register is empty, or is being consumed in that same cycle, load it and set `rx_valid`=1.
  - Otherwise pulse `overrun`, drop the new word, and keep the old word.
  - `rx_valid` clears on `rx_valid` & `rx_ready` unless a new word loads in the same cycle; the load wins.
- Latency: `linkrx` pin to first IDLE detection is SYNC_STAGES cycles. Stop-dibit sample to `rx_valid` is 1 cycle.
- `frame_err` and `overrun` are never asserted in the same cycle.

Optional Feature:
- Macro HL2LINK_RX_PARITY_EN.
- Defined:
  - In STOP, the stored parity dibit is compared with the accumulated parity.
  - On mismatch with a good stop: pulse `frame_err`, drop the word, → IDLE.
- Undefined:
  - The parity dibit is sampled and discarded; parity accumulators are not built.
  - `frame_err` reflects the stop dibit only.

Test Plan:
- Reset, OVERSAMPLE=4. Send a frame with data 0xDEADBEEF, correct parity, stop 11. Expected: `rx_valid`=1 one cycle after the stop sample, `rx_data`=0xDEADBEEF, no error pulses. Asserting `rx_ready` clears `rx_valid` the next cycle.
- Drive lanes 2'b00 for 1 cycle, then back to 11. Expected: FSM returns to IDLE, `busy` low again within OVERSAMPLE cycles, no `rx_valid`, no `frame_err`.
- Send frame 0x12345678 with stop 2'b01. Expected: one `frame_err` pulse, `rx_valid` stays 0, `busy` holds until lanes return to 11.
- Hold `rx_ready`=0 and send 0x00000001 then 0x00000002 back to back. Expected: `rx_data`=0x00000001, one `overrun` pulse on the second frame. Repeat with `rx_ready`=1 in the delivery cycle: `rx_data`=0x00000002, no overrun.
- Assert `rst` at data dibit 8 of a frame, then send a clean frame 0xA5A5A5A5. Expected: no output and no error from the aborted frame; the clean frame is received correctly.
- With HL2LINK_RX_PARITY_EN defined, send 0xCAFEF00D with lane-0 parity inverted. Expected: one `frame_err` pulse, no `rx_valid`. Without the macro, the same stimulus delivers 0xCAFEF00D.

Source files
------------

// File: rtl/hl2link_rx.sv
// Receive end of the 2-lane HL2 inter-board link: oversampled dibit deserializer delivering 32-bit words.
// Optional parity checking is enabled by defining HL2LINK_RX_PARITY_EN.
module hl2link_rx #(
  parameter int unsigned OVERSAMPLE  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  linkrx,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy
);

  localparam int unsigned PW = $clog2(OVERSAMPLE);
  localparam int unsigned SW = 2 * SYNC_STAGES;
  localparam logic [PW-1:0] PH_ONE  = PW'(1);
  localparam logic [PW-1:0] PH_MID  = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAITIDLE
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sync_q;
  logic [PW-1:0] phase_q, phase_d, phase_nxt;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   shreg_q, shreg_d;
  logic [31:0]   rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          busy_q, busy_d;
  logic          deliver;
  logic [1:0]    lanes;
  logic          sample;
  logic          consume;
`ifdef HL2LINK_RX_PARITY_EN
  logic [1:0]    par_q, par_d;
  logic [1:0]    pstore_q, pstore_d;
`endif

  // Each lane pair shifts through SYNC_STAGES flops; the oldest pair is the usable lane value.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SW-3:0], linkrx};
  end

  assign lanes     = sync_q[SW-1 -: 2];
  assign sample    = (phase_q == PH_LAST);
  assign phase_nxt = sample ? '0 : phase_q + PH_ONE;
  assign consume   = rx_valid_q & rx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      cnt_q       <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef HL2LINK_RX_PARITY_EN
      par_q       <= '0;
      pstore_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
`ifdef HL2LINK_RX_PARITY_EN
      par_q       <= par_d;
      pstore_q    <= pstore_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver     = 1'b0;
`ifdef HL2LINK_RX_PARITY_EN
    par_d       = par_q;
    pstore_d    = pstore_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (lanes == 2'b00) begin
          state_d = S_START;
          phase_d = PH_ONE;
        end
      end
      // Re-check the start dibit at its midpoint to reject glitches.
      S_START: begin
        if (phase_q == PH_MID) begin
          phase_d = '0;
          cnt_d   = '0;
`ifdef HL2LINK_RX_PARITY_EN
          par_d   = '0;
`endif
          state_d = (lanes == 2'b00) ? S_DATA : S_IDLE;
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end
      S_DATA: begin
        phase_d = phase_nxt;
        if (sample) begin
          shreg_d = {shreg_q[29:0], lanes};
          cnt_d   = cnt_q + 4'd1;
`ifdef HL2LINK_RX_PARITY_EN
          par_d   = par_q ^ lanes;
`endif
          if (cnt_q == 4'd15) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        phase_d = phase_nxt;
        if (sample) begin
`ifdef HL2LINK_RX_PARITY_EN
          pstore_d = lanes;
`endif
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        phase_d = phase_nxt;
        if (sample) begin
          if (lanes != 2'b11) begin
            frame_err_d = 1'b1;
            state_d     = S_WAITIDLE;
          end else begin
`ifdef HL2LINK_RX_PARITY_EN
            if (pstore_q != par_q) frame_err_d = 1'b1;
            else                   deliver     = 1'b1;
`else
            deliver = 1'b1;
`endif
            state_d = S_IDLE;
          end
        end
      end
      S_WAITIDLE: begin
        if (lanes == 2'b11) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Holding register: a same-cycle load beats the consume-clear.
    if (consume) rx_valid_d = 1'b0;
    if (deliver) begin
      if (!rx_valid_q || consume) begin
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule
